// File: rtl/c512to8_pkg.sv
// Shared constants, control-word field layout and FSM encoding for the
// 480-bit word to byte-stream serialiser.
package c512to8_pkg;

   localparam int unsigned DataWidth = 480;
   localparam int unsigned CtrlWidth = 32;
   localparam int unsigned NumBytes  = DataWidth / 8;

   // Control word layout: {src_port, dst_port, pcie_port, next_output}
   localparam int unsigned FieldWidth    = 8;
   localparam int unsigned SrcPortLo     = 24;
   localparam int unsigned DstPortLo     = 16;
   localparam int unsigned PciePortLo    = 8;
   localparam int unsigned NextOutputLo  = 0;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StSend = 1'b1
   } state_e;

   function automatic logic [FieldWidth-1:0] ctl_src_port(input logic [CtrlWidth-1:0] ctl);
      return ctl[SrcPortLo +: FieldWidth];
   endfunction

   function automatic logic [FieldWidth-1:0] ctl_dst_port(input logic [CtrlWidth-1:0] ctl);
      return ctl[DstPortLo +: FieldWidth];
   endfunction

   function automatic logic [FieldWidth-1:0] ctl_pcie_port(input logic [CtrlWidth-1:0] ctl);
      return ctl[PciePortLo +: FieldWidth];
   endfunction

   function automatic logic [FieldWidth-1:0] ctl_next_output(input logic [CtrlWidth-1:0] ctl);
      return ctl[NextOutputLo +: FieldWidth];
   endfunction

endpackage

// File: rtl/c512to8_word_fifo.sv
// Small synchronous word FIFO with registered full flag and simultaneous
// push/pop support (a push at full succeeds when a pop happens the same cycle).
module c512to8_word_fifo #(
   parameter int unsigned WIDTH = 512,
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             full_q, full_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && ((count_q != CntW'(DEPTH)) || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CntW'(1);
      end
      full_d = (count_d == CntW'(DEPTH));
   end

   // Storage is not reset; the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = full_q;

endmodule

// File: rtl/c512to8.sv
// Buffers write-strobed {ctl, data} words and re-serialises each one as a
// ready/valid byte stream, MSB byte first, with sop/eop markers.
module c512to8
   import c512to8_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DataWidth,
   parameter int unsigned CTRL_WIDTH = CtrlWidth,
   parameter int unsigned NUM_BYTES  = NumBytes,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_wr,
   input  logic [CTRL_WIDTH-1:0] in_ctl,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [7:0]            out_byte,
   output logic                  out_sop,
   output logic                  out_eop,
   output logic [CTRL_WIDTH-1:0] out_ctl,
   output logic                  in_full,
   output logic [CNT_WIDTH-1:0]  drop_cnt
);

   localparam int unsigned FifoW    = CTRL_WIDTH + DATA_WIDTH;
   localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned IdxW     = $clog2(NUM_BYTES);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_BYTES - 1);

   logic [FifoW-1:0]      fifo_rdata;
   logic [CTRL_WIDTH-1:0] fifo_ctl;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic [FifoCntW-1:0]   fifo_count;
   logic                  fifo_full, fifo_empty;
   logic                  fifo_push, pop;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [CTRL_WIDTH-1:0] ctl_q, ctl_d;
   logic                  valid_q, valid_d;
   logic                  sop_q, sop_d;
   logic                  eop_q, eop_d;
   logic [CNT_WIDTH-1:0]  drop_q, drop_d;

   assign fifo_ctl  = fifo_rdata[FifoW-1 -: CTRL_WIDTH];
   assign fifo_data = fifo_rdata[DATA_WIDTH-1:0];

   c512to8_word_fifo #(
      .WIDTH (FifoW),
      .DEPTH (FIFO_DEPTH)
   ) u_word_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (pop),
      .wdata ({in_ctl, in_data}),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      ctl_d     = ctl_q;
      valid_d   = valid_q;
      sop_d     = sop_q;
      eop_d     = eop_q;
      drop_d    = drop_q;
      pop       = 1'b0;
      fifo_push = 1'b0;

      unique case (state_q)
         StIdle: begin
            pop = !fifo_empty;
         end
         StSend: begin
            // Nothing moves while the consumer stalls, so every output holds.
            if (out_ready) begin
               if (idx_q != IdxLast) begin
                  shift_d = {shift_q[DATA_WIDTH-9:0], 8'h00};
                  idx_d   = idx_q + IdxW'(1);
                  sop_d   = 1'b0;
                  eop_d   = (idx_d == IdxLast);
               end else if (!fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  state_d = StIdle;
                  valid_d = 1'b0;
                  sop_d   = 1'b0;
                  eop_d   = 1'b0;
               end
            end
         end
      endcase

      // A load from IDLE and a load right after an accepted last byte look alike.
      if (pop) begin
         state_d = StSend;
         shift_d = fifo_data;
         ctl_d   = fifo_ctl;
         idx_d   = '0;
         valid_d = 1'b1;
         sop_d   = 1'b1;
         eop_d   = 1'b0;
      end

      if (in_wr) begin
         if ((fifo_count != FifoCntW'(FIFO_DEPTH)) || pop) begin
            fifo_push = 1'b1;
         end else if (drop_q != '1) begin
            drop_d = drop_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         shift_q <= '0;
         idx_q   <= '0;
         ctl_q   <= '0;
         valid_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         ctl_q   <= ctl_d;
         valid_q <= valid_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         drop_q  <= drop_d;
      end
   end

   assign out_valid = valid_q;
   assign out_byte  = shift_q[DATA_WIDTH-1 -: 8];
   assign out_sop   = sop_q;
   assign out_eop   = eop_q;
   assign out_ctl   = ctl_q;
   assign in_full   = fifo_full;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_c512to8.sv
// Bench for c512to8: directed sequences, a small vector table and a random
// run, all checked against a queue-based word/byte reference model.
module tb_c512to8;

   localparam int DW    = 480;
   localparam int CW    = 32;
   localparam int NB    = 60;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst, in_wr, out_ready;
   logic [CW-1:0] in_ctl;
   logic [DW-1:0] in_data;
   logic          out_valid, out_sop, out_eop, in_full;
   logic [7:0]    out_byte;
   logic [CW-1:0] out_ctl;
   logic [15:0]   drop_cnt;

   always #5 clk = ~clk;

   c512to8 dut (
      .clk       (clk),
      .rst       (rst),
      .in_wr     (in_wr),
      .in_ctl    (in_ctl),
      .in_data   (in_data),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_byte  (out_byte),
      .out_sop   (out_sop),
      .out_eop   (out_eop),
      .out_ctl   (out_ctl),
      .in_full   (in_full),
      .drop_cnt  (drop_cnt)
   );

   typedef struct {
      logic [CW-1:0] ctl;
      logic [DW-1:0] data;
   } word_t;

   typedef struct {
      bit wr;
      bit rdy;
      bit e_valid;
      bit e_sop;
      bit e_full;
      int e_drop;
   } vec_t;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: buffered words, the word being sent and its byte position.
   word_t mq[$];
   word_t m_cur;
   bit    m_busy;
   int    m_sent;
   int    m_drops;

   int t_idx, t_first, t_last, t_nvalid, t_nsop, t_neop;
   bit t_first_sop;
   logic [CW-1:0] t_eop_ctl;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit w, input word_t wd, input bit rdy);
      bit pop, acc;
      if (!r) begin
         mq.delete();
         m_busy  = 1'b0;
         m_sent  = 0;
         m_drops = 0;
         return;
      end
      pop = (mq.size() > 0) && (!m_busy || (rdy && m_sent == NB - 1));
      acc = w && ((mq.size() < DEPTH) || pop);
      if (m_busy && rdy) begin
         if (m_sent < NB - 1) m_sent++;
         else m_busy = 1'b0;
      end
      if (pop) begin
         m_cur  = mq.pop_front();
         m_busy = 1'b1;
         m_sent = 0;
      end
      if (acc) mq.push_back(wd);
      else if (w && m_drops < 65535) m_drops++;
   endtask

   task automatic model_check();
      chk("model_valid", out_valid, m_busy);
      chk("model_sop", out_sop, m_busy && m_sent == 0);
      chk("model_eop", out_eop, m_busy && m_sent == NB - 1);
      if (m_busy) begin
         chk("model_byte", out_byte, m_cur.data[DW-1-8*m_sent -: 8]);
         chk("model_ctl", out_ctl, m_cur.ctl);
      end
      chk("model_full", in_full, mq.size() == DEPTH);
      chk("model_drop", drop_cnt, m_drops);
   endtask

   task automatic cycle(input bit r, input bit w, input word_t wd, input bit rdy);
      rst       = r;
      in_wr     = w;
      in_ctl    = wd.ctl;
      in_data   = wd.data;
      out_ready = rdy;
      model_step(r, w, wd, rdy);
      @(posedge clk);
      #1;
      model_check();
   endtask

   task automatic tally_reset();
      t_idx = 0; t_first = 0; t_last = 0; t_nvalid = 0; t_nsop = 0; t_neop = 0;
      t_first_sop = 1'b0;
      t_eop_ctl   = '0;
   endtask

   task automatic tally();
      if (out_valid) begin
         if (t_nvalid == 0) begin
            t_first     = t_idx;
            t_first_sop = out_sop;
         end
         t_last = t_idx;
         t_nvalid++;
         if (out_sop) t_nsop++;
         if (out_eop) begin
            t_neop++;
            t_eop_ctl = out_ctl;
         end
      end
      t_idx++;
   endtask

   function automatic word_t seq_word(input logic [CW-1:0] c);
      word_t w;
      w.ctl = c;
      for (int i = 0; i < NB; i++) w.data[DW-1-8*i -: 8] = 8'(i + 1);
      return w;
   endfunction

   function automatic word_t rand_word(input logic [CW-1:0] c);
      word_t w;
      w.ctl = c;
      for (int k = 0; k < DW / 32; k++) w.data[32*k +: 32] = $urandom;
      if ($urandom_range(0, 3) == 0) w.data[DW/2-1:0] = '0;
      return w;
   endfunction

   initial begin
      word_t z, wa, wb, wc, we;
      word_t ov_w[5];
      vec_t  tbl[5];
      bit    rdy;
      int    eb;

      z = '{ctl: '0, data: '0};

      // Reset state
      cycle(1'b0, 1'b0, z, 1'b0);
      cycle(1'b0, 1'b0, z, 1'b0);
      chk("reset_outputs", {out_valid, out_byte, out_sop, out_eop, out_ctl, in_full, drop_cnt}, '0);
      cycle(1'b1, 1'b0, z, 1'b0);

      // Single word, latency N+2 and full byte order
      wa = seq_word(32'h11223344);
      cycle(1'b1, 1'b1, wa, 1'b1);
      chk("single_n1_idle", out_valid, 1'b0);
      cycle(1'b1, 1'b0, z, 1'b1);
      for (int i = 0; i < NB; i++) begin
         chk("single_beat", {out_valid, out_sop, out_eop, out_byte, out_ctl},
             {1'b1, 1'(i == 0), 1'(i == NB - 1), 8'(i + 1), 32'h11223344});
         cycle(1'b1, 1'b0, z, 1'b1);
      end
      chk("single_done", out_valid, 1'b0);

      // Backpressure on transfer cycles 5..9
      cycle(1'b1, 1'b1, wa, 1'b1);
      cycle(1'b1, 1'b0, z, 1'b1);
      for (int t = 1; t <= 65; t++) begin
         rdy = !(t >= 5 && t <= 9);
         eb  = (t < 5) ? t : ((t <= 10) ? 5 : t - 5);
         chk("bp_beat", {out_valid, out_sop, out_eop, out_byte},
             {1'b1, 1'(t == 1), 1'(t == 65), 8'(eb)});
         cycle(1'b1, 1'b0, z, rdy);
      end
      chk("bp_done", out_valid, 1'b0);

      // Back-to-back words with no bubble
      wa = rand_word(32'hA0000001);
      wb = rand_word(32'hA0000002);
      wc = rand_word(32'hA0000003);
      tally_reset();
      cycle(1'b1, 1'b1, wa, 1'b1); tally();
      cycle(1'b1, 1'b1, wb, 1'b1); tally();
      cycle(1'b1, 1'b1, wc, 1'b1); tally();
      for (int i = 0; i < 190; i++) begin
         cycle(1'b1, 1'b0, z, 1'b1);
         tally();
      end
      chk("b2b_nvalid", t_nvalid, 180);
      chk("b2b_contig", t_last - t_first + 1, 180);
      chk("b2b_nsop", t_nsop, 3);
      chk("b2b_neop", t_neop, 3);
      chk("b2b_last_ctl", t_eop_ctl, 32'hA0000003);
      chk("b2b_drop", drop_cnt, 0);

      // Overflow: four strobes with the consumer stalled
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1};
      for (int r = 0; r < 5; r++) ov_w[r] = rand_word(32'hB0000000 + r);
      for (int r = 0; r < 5; r++) begin
         cycle(1'b1, tbl[r].wr, ov_w[r], tbl[r].rdy);
         chk("ovf_row", {out_valid, out_sop, in_full, drop_cnt},
             {tbl[r].e_valid, tbl[r].e_sop, tbl[r].e_full, 16'(tbl[r].e_drop)});
      end
      chk("ovf_head_ctl", out_ctl, ov_w[0].ctl);

      // Push at full coinciding with the pop after the last byte
      for (int i = 0; i < NB - 1; i++) cycle(1'b1, 1'b0, z, 1'b1);
      chk("paf_last_byte", out_eop, 1'b1);
      we = rand_word(32'hE0000005);
      cycle(1'b1, 1'b1, we, 1'b1);
      chk("paf_drop", drop_cnt, 1);
      chk("paf_full", in_full, 1'b1);
      chk("paf_second", {out_valid, out_sop, out_ctl}, {1'b1, 1'b1, ov_w[1].ctl});
      for (int i = 0; i < 2 * NB; i++) cycle(1'b1, 1'b0, z, 1'b1);
      chk("paf_third", {out_valid, out_sop, out_ctl}, {1'b1, 1'b1, we.ctl});
      for (int i = 0; i < NB; i++) cycle(1'b1, 1'b0, z, 1'b1);
      chk("paf_done", out_valid, 1'b0);

      // Reset in the middle of a word
      wa = seq_word(32'hCAFE0001);
      cycle(1'b1, 1'b1, wa, 1'b1);
      cycle(1'b1, 1'b0, z, 1'b1);
      for (int i = 0; i < 29; i++) cycle(1'b1, 1'b0, z, 1'b1);
      chk("rmid_byte30", out_byte, 8'd30);
      cycle(1'b0, 1'b0, z, 1'b1);
      chk("rmid_outputs", {out_valid, out_byte, out_sop, out_eop, out_ctl, in_full, drop_cnt}, '0);
      wb = seq_word(32'hCAFE0002);
      tally_reset();
      cycle(1'b1, 1'b1, wb, 1'b1); tally();
      for (int i = 0; i < 70; i++) begin
         cycle(1'b1, 1'b0, z, 1'b1);
         tally();
      end
      chk("rmid_first_sop", t_first_sop, 1'b1);
      chk("rmid_nvalid", t_nvalid, NB);
      chk("rmid_neop", t_neop, 1);
      chk("rmid_eop_ctl", t_eop_ctl, 32'hCAFE0002);

      // Random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         cycle($urandom_range(0, 1999) != 0, $urandom_range(0, 99) < 3,
               rand_word($urandom), $urandom_range(0, 9) < 7);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
